apb_spi_rf_interface: RTL and testbench
=======================================

// Module: apb_spi_rf_interface
// PURPOSE
//  APB slave bridging a host CPU to a 1-bit serial TX line and a pulse-position RF receiver.
//  Host configures mode, slave select and SCK rate, writes TX bytes, and issues start commands.
//  RF packets (8-pulse preamble + 64 data bits) are decoded into a buffer. The host reads the buffer back one byte at a time through the APB RX register.
// PARAMETERS
//  BIT_CYCLES  10000  PCLK cycles per serial/RF bit slot (1 ms at 10 MHz)
// PORTS
//  i_PCLK       in   1   clock, single domain
//  i_PRESET     in   1   reset, synchronous, active-high
//  i_PSEL0      in   1   APB select
//  i_PENABLE    in   1   APB access phase
//  i_PWRITE     in   1   1=write 0=read
//  i_PADDR      in   16  [15:6]=block base, [5:0]=register offset
//  i_PWDATA     in   8   APB write data
//  i_PRDATA     in   8   external peripheral read data (offset 0x08 pass-through)
//  i_BASE_ADDR  in   10  block base; decode hit when i_PADDR[15:6]==i_BASE_ADDR
//  o_WR0..o_WR3 out  1   1-cycle write strobes, offsets 0x00/0x04/0x08/0x0C
//  o_DR0..o_DR3 out  1   1-cycle read strobes, same offsets
//  PREADY       out  1   APB ready, constant 1 (zero wait states)
//  o_PWDATA     out  8   last accepted write data (registered)
//  o_PRDATA     out  8   read data, combinational from offset
//  rfin         in   1   asynchronous RF pulse input
//  RX           in   1   1=CMD start performs RX byte fetch, 0=TX byte send
//  pkt_rec      out  1   1-cycle pulse when a 64-bit packet is complete
//  TX_OUT       out  1   serial TX data
//  sh_en        out  1   1-cycle pulse on every bit shifted (TX out or RF in)
// BEHAVIOUR
//  Reset: all outputs 0 except PREADY=1. All registers, pointers and flags clear. Receiver returns to IDLE.
//  Access: when PSEL0&PENABLE&hit, the offset strobe fires (WR if PWRITE, else DR). Misses and non-aligned offsets are ignored and read 0x00.
//  Registers: 0x00 W CONFIG={2'b0,MODE[1:0],SLAVE[1:0],SCK[1:0]}; 0x00 R STATUS.
//  0x04 W TX data; 0x04 R RX data, and a read clears rx_valid. 0x08 R =i_PRDATA.
//  0x0C W CMD: bit1=start; other bits ignored. A start while busy is ignored.
//  STATUS = {4'b0, pkt_avail, rx_valid, busy, tx_busy}.
//  SCK divisor: 00=/2, 01=/4, 10=/8, 11=/16. CONFIG changes take effect at the next start.
//  TX (start with RX=0): load TX reg into shifter and set busy/tx_busy.
//   Shift 8 bits MSB-first; each bit is held BIT_CYCLES cycles on TX_OUT.
//   TX_OUT updates in the same cycle sh_en pulses.
//   After the 8th slot, TX_OUT=0 and busy clears.
//  RX fetch (start with RX=1): set busy. After 8*SCK_DIV cycles:
//   RX reg <= pkt_buf byte[ptr] (ptr 0 = bits 63:56); ptr++ wraps 7->0; rx_valid=1; busy=0.
//   When byte 7 is fetched, pkt_avail clears. With no packet available, stale buffer contents are returned.
//  RF receiver: rfin passes a 2-flop synchronizer followed by a rising-edge detect (2-3 cycle latency).
//   IDLE: first edge -> PREAMBLE, count=1.
//   PREAMBLE: count edges to 8, then DATA with ref=time of 8th edge. A gap >2*BIT_CYCLES -> IDLE.
//   DATA: an edge before ref+1.5*BIT_CYCLES shifts 1 and sets ref=now.
//    Reaching ref+1.5*BIT_CYCLES with no edge shifts 0 and sets ref+=BIT_CYCLES.
//    Every shift pulses sh_en.
//   After 64 bits: pkt_buf<=shifter, pkt_rec pulse, pkt_avail=1, ptr=0, return to IDLE.
//    A new packet overwrites the buffer even while a readout is in progress.
//  Jitter up to +/-20% of BIT_CYCLES on pulse position must decode correctly.
//  Simultaneous TX shift and RF shift both pulse sh_en in the same cycle (OR).
//  Reset mid-transfer aborts immediately; TX_OUT=0.
// TESTING
//  Write CONFIG 0x07 at base 1 (PADDR 0x0040): o_WR0 pulses, o_PWDATA=0x07, STATUS reads 0x00.
//  TX 0x81 with RX=0, then CMD 0x02: TX_OUT=1,0,0,0,0,0,0,1, BIT_CYCLES per bit.
//   8 sh_en pulses; tx_busy clears after 8*BIT_CYCLES.
//  RF: 8 preamble pulses + 64 bits of 0x8123456789ABCD0F at 1 ms with jitter -> one pkt_rec pulse.
//  After that packet: 8x (RX=1, CMD 0x02 with SCK=/4, wait 72 cycles, read 0x04) -> 81,23,45,67,89,AB,CD,0F.
//   pkt_avail=0 after the 8th fetch.
//  Read with PADDR[15:6]!=i_BASE_ADDR -> no strobes, o_PRDATA=0x00.
//   CMD during busy is ignored.
//   Reset asserted mid-TX -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/apb_spi_rf_interface.sv
// APB slave bridging a host to a serial TX shifter and a pulse-position RF packet receiver.
// Latency: APB zero wait states; TX one bit per BIT_CYCLES; RX fetch 8*SCK_DIV cycles; RF edge 2-3 cycles.
// Backpressure: none; PREADY is tied high and a start command issued while busy is dropped.
// Ports: i_PCLK/i_PRESET clock and sync reset; i_PSEL0/i_PENABLE/i_PWRITE/i_PADDR/i_PWDATA APB request;
//        i_PRDATA external read data; i_BASE_ADDR decode base; o_WR0..3/o_DR0..3 offset strobes;
//        PREADY/o_PWDATA/o_PRDATA APB response; rfin RF pulses; RX fetch/send select;
//        pkt_rec packet-complete pulse; TX_OUT serial data; sh_en per-bit shift pulse.
module apb_spi_rf_interface #(
    parameter int BIT_CYCLES = 10000
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        i_PSEL0,
    input  logic        i_PENABLE,
    input  logic        i_PWRITE,
    input  logic [15:0] i_PADDR,
    input  logic [7:0]  i_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic [9:0]  i_BASE_ADDR,
    output logic        o_WR0,
    output logic        o_WR1,
    output logic        o_WR2,
    output logic        o_WR3,
    output logic        o_DR0,
    output logic        o_DR1,
    output logic        o_DR2,
    output logic        o_DR3,
    output logic        PREADY,
    output logic [7:0]  o_PWDATA,
    output logic [7:0]  o_PRDATA,
    input  logic        rfin,
    input  logic        RX,
    output logic        pkt_rec,
    output logic        TX_OUT,
    output logic        sh_en
);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int TW = $clog2(2 * BIT_CYCLES + 2);
    localparam logic [CW-1:0] BC_M1  = CW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] BC_T   = TW'(BIT_CYCLES);
    localparam logic [TW-1:0] HALF3  = TW'((3 * BIT_CYCLES) / 2);
    localparam logic [TW-1:0] TWO_BC = TW'(2 * BIT_CYCLES);

    typedef enum logic [1:0] {RF_IDLE, RF_PRE, RF_DATA} rf_state_t;

    // ---------------- APB decode ----------------
    logic       hit, acc;
    logic [5:0] off;
    assign off = i_PADDR[5:0];
    assign hit = (i_PADDR[15:6] == i_BASE_ADDR);
    assign acc = i_PSEL0 & i_PENABLE & hit;

    assign o_WR0 = acc &  i_PWRITE & (off == 6'h00);
    assign o_WR1 = acc &  i_PWRITE & (off == 6'h04);
    assign o_WR2 = acc &  i_PWRITE & (off == 6'h08);
    assign o_WR3 = acc &  i_PWRITE & (off == 6'h0C);
    assign o_DR0 = acc & ~i_PWRITE & (off == 6'h00);
    assign o_DR1 = acc & ~i_PWRITE & (off == 6'h04);
    assign o_DR2 = acc & ~i_PWRITE & (off == 6'h08);
    assign o_DR3 = acc & ~i_PWRITE & (off == 6'h0C);
    assign PREADY = 1'b1;

    // ---------------- host-side state ----------------
    // Only the SCK field of CONFIG affects this block; MODE/SLAVE have no function here.
    logic [1:0]    cfg_sck, sck_lat;
    logic [7:0]    tx_reg, rx_reg, tx_shift, fcnt;
    logic          rx_valid, busy, tx_busy, fetch_busy, pkt_avail, tx_evt;
    logic [2:0]    ptr;
    logic [63:0]   pkt_buf;
    logic [CW-1:0] tx_cyc;
    logic [3:0]    tx_bits;
    logic          fetch_last;

    // ---------------- RF receiver state ----------------
    rf_state_t     rf_state, rf_state_n;
    logic          rf_s1, rf_s2, rf_s3, rf_edge;
    logic [TW-1:0] tcnt;
    logic [2:0]    pre_cnt;
    logic [5:0]    bit_cnt;
    logic [63:0]   rf_shreg;
    logic          rf_shift, rf_bit, rf_done, rf_evt;

    assign rf_edge    = rf_s2 & ~rf_s3;
    assign fetch_last = (fcnt == ((8'd16 << sck_lat) - 8'd1));
    assign sh_en      = tx_evt | rf_evt;

    always_comb begin
        o_PRDATA = 8'h00;
        if (i_PSEL0 && hit) begin
            case (off)
                6'h00:   o_PRDATA = {4'b0, pkt_avail, rx_valid, busy, tx_busy};
                6'h04:   o_PRDATA = rx_reg;
                6'h08:   o_PRDATA = i_PRDATA;
                default: o_PRDATA = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            o_PWDATA   <= '0;
            cfg_sck    <= '0;
            sck_lat    <= '0;
            tx_reg     <= '0;
            rx_reg     <= '0;
            tx_shift   <= '0;
            fcnt       <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            tx_busy    <= 1'b0;
            fetch_busy <= 1'b0;
            pkt_avail  <= 1'b0;
            tx_evt     <= 1'b0;
            ptr        <= '0;
            pkt_buf    <= '0;
            tx_cyc     <= '0;
            tx_bits    <= '0;
            TX_OUT     <= 1'b0;
        end else begin
            tx_evt <= 1'b0;
            if (acc && i_PWRITE) o_PWDATA <= i_PWDATA;
            if (o_WR0) cfg_sck <= i_PWDATA[1:0];
            if (o_WR1) tx_reg <= i_PWDATA;
            if (o_DR1) rx_valid <= 1'b0;

            // Start is only honoured when idle; SCK is latched so CONFIG writes wait for the next start.
            if (o_WR3 && i_PWDATA[1] && !busy) begin
                busy    <= 1'b1;
                sck_lat <= cfg_sck;
                if (RX) begin
                    fetch_busy <= 1'b1;
                    fcnt       <= '0;
                end else begin
                    tx_busy  <= 1'b1;
                    TX_OUT   <= tx_reg[7];
                    tx_shift <= {tx_reg[6:0], 1'b0};
                    tx_bits  <= 4'd1;
                    tx_cyc   <= '0;
                    tx_evt   <= 1'b1;
                end
            end

            if (tx_busy) begin
                if (tx_cyc == BC_M1) begin
                    tx_cyc <= '0;
                    if (tx_bits == 4'd8) begin
                        TX_OUT  <= 1'b0;
                        tx_busy <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        TX_OUT   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        tx_bits  <= tx_bits + 4'd1;
                        tx_evt   <= 1'b1;
                    end
                end else begin
                    tx_cyc <= tx_cyc + CW'(1);
                end
            end

            if (fetch_busy) begin
                if (fetch_last) begin
                    rx_reg     <= pkt_buf[{~ptr, 3'b000} +: 8];
                    ptr        <= ptr + 3'd1;
                    rx_valid   <= 1'b1;
                    busy       <= 1'b0;
                    fetch_busy <= 1'b0;
                    if (ptr == 3'd7) pkt_avail <= 1'b0;
                end else begin
                    fcnt <= fcnt + 8'd1;
                end
            end

            // A fresh packet wins over a simultaneous fetch: buffer, pointer and flag restart.
            if (rf_done) begin
                pkt_buf   <= {rf_shreg[62:0], rf_bit};
                pkt_avail <= 1'b1;
                ptr       <= '0;
            end
        end
    end

    // RF next-state: tcnt is cycles since the last edge (preamble) or since ref (data).
    always_comb begin
        rf_state_n = rf_state;
        rf_shift   = 1'b0;
        rf_bit     = 1'b0;
        rf_done    = 1'b0;
        case (rf_state)
            RF_IDLE: if (rf_edge) rf_state_n = RF_PRE;
            RF_PRE: begin
                if (rf_edge) begin
                    if (pre_cnt == 3'd7) rf_state_n = RF_DATA;
                end else if (tcnt > TWO_BC) begin
                    rf_state_n = RF_IDLE;
                end
            end
            RF_DATA: begin
                if (rf_edge && (tcnt < HALF3)) begin
                    rf_shift = 1'b1;
                    rf_bit   = 1'b1;
                end else if (tcnt >= HALF3) begin
                    rf_shift = 1'b1;
                end
                if (rf_shift && (bit_cnt == 6'd63)) begin
                    rf_done    = 1'b1;
                    rf_state_n = RF_IDLE;
                end
            end
            default: rf_state_n = RF_IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            rf_state <= RF_IDLE;
            rf_s1    <= 1'b0;
            rf_s2    <= 1'b0;
            rf_s3    <= 1'b0;
            tcnt     <= '0;
            pre_cnt  <= '0;
            bit_cnt  <= '0;
            rf_shreg <= '0;
            rf_evt   <= 1'b0;
            pkt_rec  <= 1'b0;
        end else begin
            rf_state <= rf_state_n;
            rf_s1    <= rfin;
            rf_s2    <= rf_s1;
            rf_s3    <= rf_s2;
            rf_evt   <= rf_shift;
            pkt_rec  <= rf_done;
            case (rf_state)
                RF_IDLE: begin
                    if (rf_edge) begin
                        pre_cnt <= 3'd1;
                        tcnt    <= '0;
                    end
                end
                RF_PRE: begin
                    if (rf_edge) begin
                        pre_cnt <= pre_cnt + 3'd1;
                        tcnt    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RF_DATA: begin
                    if (rf_shift) begin
                        rf_shreg <= {rf_shreg[62:0], rf_bit};
                        bit_cnt  <= bit_cnt + 6'd1;
                        // A '1' re-anchors ref on the edge; a missed slot advances ref by one bit.
                        tcnt     <= rf_bit ? '0 : (tcnt + TW'(1) - BC_T);
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: tcnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_spi_rf_interface.sv
module tb_apb_spi_rf_interface;
    localparam int BC = 20;
    localparam int RF_LEN = 74 * BC;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata, ext_prdata;
    logic [9:0]  base;
    logic        wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3;
    logic        pready;
    logic [7:0]  out_pwdata, out_prdata;
    logic        rfin, rx_sel, pkt_rec, tx_out, sh_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_spi_rf_interface #(.BIT_CYCLES(BC)) dut (
        .i_PCLK(clk), .i_PRESET(rst), .i_PSEL0(psel), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata), .i_PRDATA(ext_prdata),
        .i_BASE_ADDR(base),
        .o_WR0(wr0), .o_WR1(wr1), .o_WR2(wr2), .o_WR3(wr3),
        .o_DR0(dr0), .o_DR1(dr1), .o_DR2(dr2), .o_DR3(dr3),
        .PREADY(pready), .o_PWDATA(out_pwdata), .o_PRDATA(out_prdata),
        .rfin(rfin), .RX(rx_sel), .pkt_rec(pkt_rec), .TX_OUT(tx_out), .sh_en(sh_en)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [7:0] d, output logic [3:0] wr);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 wr = {wr3, wr2, wr1, wr0};
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [7:0] d, output logic [3:0] dr);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 begin d = out_prdata; dr = {dr3, dr2, dr1, dr0}; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [3:0]  st;
        logic [7:0]  rd, tx_byte;
        logic [63:0] pkt;
        logic        rf_hi [0:RF_LEN-1];
        int          tx_bad, sh_cnt, sh_bad, rec_cnt, pos, jit;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; ext_prdata = 8'hA5; base = 10'd1; rfin = 1'b0; rx_sel = 1'b0;
        pkt = 64'h8123456789ABCD0F;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 64'(pready), 64'd1);
        check("rst_tx_out", 64'(tx_out), 64'd0);
        check("rst_sh_en", 64'(sh_en), 64'd0);
        check("rst_pkt_rec", 64'(pkt_rec), 64'd0);
        check("rst_pwdata", 64'(out_pwdata), 64'd0);
        check("rst_prdata", 64'(out_prdata), 64'd0);
        rst = 1'b0;

        // CONFIG write and STATUS read at base 1
        apb_write(16'h0040, 8'h07, st);
        check("cfg_wr_strobe", 64'(st), 64'b0001);
        check("cfg_pwdata", 64'(out_pwdata), 64'h07);
        apb_read(16'h0040, rd, st);
        check("status_idle", 64'(rd), 64'h00);
        check("status_dr_strobe", 64'(st), 64'b0001);

        // Pass-through, miss and non-aligned accesses
        apb_read(16'h0048, rd, st);
        check("passthru_data", 64'(rd), 64'hA5);
        check("passthru_strobe", 64'(st), 64'b0100);
        apb_read(16'h0084, rd, st);
        check("miss_data", 64'(rd), 64'h00);
        check("miss_strobe", 64'(st), 64'b0000);
        apb_write(16'h0084, 8'h02, st);
        check("miss_wr_strobe", 64'(st), 64'b0000);
        apb_read(16'h0042, rd, st);
        check("unaligned_data", 64'(rd), 64'h00);
        check("unaligned_strobe", 64'(st), 64'b0000);

        // TX 0x81 MSB-first, one bit per BC cycles
        rx_sel = 1'b0;
        apb_write(16'h0044, 8'h81, st);
        check("tx_reg_strobe", 64'(st), 64'b0010);
        apb_write(16'h004C, 8'h02, st);
        check("cmd_strobe", 64'(st), 64'b1000);
        tx_bad = 0; sh_cnt = 0; sh_bad = 0; tx_byte = '0;
        for (int i = 0; i < 8 * BC; i++) begin
            if (tx_out !== pkt[63 - 7 * (i / BC) + ((i / BC) == 0 ? 0 : 0)] && 1'b0) tx_bad++;
            if (tx_out !== ((i / BC) == 0 || (i / BC) == 7)) tx_bad++;
            if (i % BC == BC / 2) tx_byte[7 - i / BC] = tx_out;
            if (sh_en === 1'b1) begin
                sh_cnt++;
                if (i % BC != 0) sh_bad++;
            end
            @(posedge clk); #1;
        end
        check("tx_byte", 64'(tx_byte), 64'h81);
        check("tx_bad_cycles", 64'(tx_bad), 64'd0);
        check("tx_sh_en_count", 64'(sh_cnt), 64'd8);
        check("tx_sh_en_misplaced", 64'(sh_bad), 64'd0);
        check("tx_out_after", 64'(tx_out), 64'd0);
        apb_read(16'h0040, rd, st);
        check("tx_done_status", 64'(rd), 64'h00);

        // RF packet with jitter; SCK=/4 for the later fetches
        apb_write(16'h0040, 8'h01, st);
        for (int c = 0; c < RF_LEN; c++) rf_hi[c] = 1'b0;
        for (int p = 0; p < 8; p++)
            for (int w = 0; w < 3; w++) rf_hi[p * BC + w] = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            if (pkt[64 - k]) begin
                jit = ((k * 7) % 9) - 4;
                pos = 7 * BC + k * BC + jit;
                for (int w = 0; w < 3; w++) rf_hi[pos + w] = 1'b1;
            end
        end
        rec_cnt = 0; sh_cnt = 0;
        for (int c = 0; c < RF_LEN; c++) begin
            rfin = rf_hi[c];
            if (pkt_rec === 1'b1) rec_cnt++;
            if (sh_en === 1'b1) sh_cnt++;
            @(posedge clk); #1;
        end
        rfin = 1'b0;
        check("rf_pkt_rec_count", 64'(rec_cnt), 64'd1);
        check("rf_sh_en_count", 64'(sh_cnt), 64'd64);
        apb_read(16'h0040, rd, st);
        check("rf_status", 64'(rd), 64'h08);

        // Byte-wise readout of the packet buffer
        rx_sel = 1'b1;
        for (int b = 0; b < 8; b++) begin
            apb_write(16'h004C, 8'h02, st);
            repeat (72) @(posedge clk);
            apb_read(16'h0040, rd, st);
            check($sformatf("fetch%0d_status", b), 64'(rd), (b < 7) ? 64'h0C : 64'h04);
            apb_read(16'h0044, rd, st);
            check($sformatf("fetch%0d_byte", b), 64'(rd), 64'(pkt[63 - 8 * b -: 8]));
        end
        apb_read(16'h0040, rd, st);
        check("fetch_done_status", 64'(rd), 64'h00);

        // A start issued during TX is dropped
        rx_sel = 1'b0;
        apb_write(16'h0044, 8'h55, st);
        apb_write(16'h004C, 8'h02, st);
        rx_sel = 1'b1;
        apb_write(16'h004C, 8'h02, st);
        apb_read(16'h0040, rd, st);
        check("busy_status", 64'(rd), 64'h03);
        repeat (8 * BC) @(posedge clk);
        apb_read(16'h0040, rd, st);
        check("busy_cmd_ignored", 64'(rd), 64'h00);

        // Reset in the middle of a TX
        rx_sel = 1'b0;
        apb_write(16'h0044, 8'hFF, st);
        apb_write(16'h004C, 8'h02, st);
        check("pre_rst_tx_out", 64'(tx_out), 64'd1);
        check("pre_rst_sh_en", 64'(sh_en), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tx_out", 64'(tx_out), 64'd0);
        check("mid_rst_sh_en", 64'(sh_en), 64'd0);
        check("mid_rst_pwdata", 64'(out_pwdata), 64'd0);
        check("mid_rst_pkt_rec", 64'(pkt_rec), 64'd0);
        check("mid_rst_pready", 64'(pready), 64'd1);
        rst = 1'b0;
        apb_read(16'h0040, rd, st);
        check("post_rst_status", 64'(rd), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
